// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the nibble-sliced ALU.
//   - Op-code encodings. These are the 4-bit select values for the 13-way
//     nibble result mux.
//   - Slice geometry: NIB_W bits per slice, N_NIBS slices per 32-bit word.
//   - Sequencer state encoding.
// ---------------------------------------------------------------------------
package alu_pkg;

  // Slice geometry for the default 32-bit datapath
  localparam int NIB_W  = 4;
  localparam int N_NIBS = 32 / NIB_W;

  // Number of legal op codes. Codes at or above this value are illegal.
  localparam int N_OPS = 13;

  // Op codes, which are also the result mux input indices
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOR   = 4'd5;
  localparam logic [3:0] OP_NAND  = 4'd6;
  localparam logic [3:0] OP_PASSA = 4'd7;
  localparam logic [3:0] OP_PASSB = 4'd8;
  localparam logic [3:0] OP_NOTA  = 4'd9;
  localparam logic [3:0] OP_XNOR  = 4'd10;
  localparam logic [3:0] OP_ANDN  = 4'd11;
  localparam logic [3:0] OP_ORN   = 4'd12;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_nibble_sequencer.sv
// ---------------------------------------------------------------------------
// alu_nibble_sequencer
// Time-multiplexed control and collection stage for the nibble-sliced ALU.
// The block accepts one DATA_W-bit command. It then walks the operands one
// NIB_W slice per cycle through the external slice logic and result mux,
// chaining carry between slices. After that it presents the assembled
// result and flags through a valid/ready handshake.
//
// Ports
//   clk, rst_n              clock; asynchronous active-low reset
//   in_valid / in_ready     command handshake
//   in_op, in_a, in_b       op code (mux select) and operands
//   in_cin                  carry into slice 0
//   slice_a, slice_b        operand nibbles for the current slice
//   slice_cin               carry into the current slice
//   mux_s                   result mux select
//   mux_y                   result mux output for the current slice (comb)
//   slice_cout              carry out of the current slice (comb)
//   out_valid / out_ready   result handshake
//   out_result              assembled result
//   out_zero/neg/carry      result == 0, result MSB, final slice carry
//   out_illegal             op code was out of range
// ---------------------------------------------------------------------------
module alu_nibble_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NIB_W  = alu_pkg::NIB_W,
  parameter int N_OPS  = alu_pkg::N_OPS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_cin,
  output logic [NIB_W-1:0]  slice_a,
  output logic [NIB_W-1:0]  slice_b,
  output logic              slice_cin,
  output logic [3:0]        mux_s,
  input  logic [NIB_W-1:0]  mux_y,
  input  logic              slice_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_carry,
  output logic              out_illegal
);

  localparam int NNIBS = DATA_W / NIB_W;
  localparam int IDX_W = (NNIBS > 1) ? $clog2(NNIBS) : 1;
  localparam int POS_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NNIBS - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_result;
  logic [3:0]        r_op;
  logic              r_carry;
  logic              r_illegal;
  logic [IDX_W-1:0]  r_idx;
  logic [POS_W-1:0]  w_pos;
  logic              w_accept;
  logic              w_opLegal;

  // A command is taken only in IDLE, so commands never overlap.
  // The op check is one bit wider than in_op. This keeps it correct even
  // when N_OPS is 16.
  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_opLegal = ({1'b0, in_op} < 5'(N_OPS));
  assign w_pos     = POS_W'(r_idx * NIB_W);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. An illegal op skips RUN and goes straight to DONE
  // with a forced zero result.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_nextState = w_opLegal ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (r_idx == LAST_IDX) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Slice-side drive. These outputs are live only in RUN. Elsewhere they
  // are held at zero so the external slice logic sees a quiet input.
  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    mux_s     = '0;
    if (r_state == S_RUN) begin
      slice_a   = r_a[w_pos +: NIB_W];
      slice_b   = r_b[w_pos +: NIB_W];
      slice_cin = r_carry;
      mux_s     = r_op;
    end
  end

  // Datapath registers. The carry register starts as in_cin. Each RUN cycle
  // then loads the slice carry-out, so after the last slice it holds the
  // word carry. mux_y is captured directly, with no pipeline stage in
  // between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_idx     <= '0;
      r_result  <= '0;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_a       <= in_a;
      r_b       <= in_b;
      r_op      <= in_op;
      r_idx     <= '0;
      r_result  <= '0;
      r_carry   <= w_opLegal ? in_cin : 1'b0;
      r_illegal <= !w_opLegal;
    end else if (r_state == S_RUN) begin
      r_result[w_pos +: NIB_W] <= mux_y;
      r_carry                  <= slice_cout;
      r_idx                    <= r_idx + 1'b1;
    end
  end

  // Handshake and result outputs. All of them derive from registers only.
  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign out_result  = r_result;
  assign out_zero    = (r_result == '0);
  assign out_neg     = r_result[DATA_W-1];
  assign out_carry   = r_carry;
  assign out_illegal = r_illegal;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_nibble_sequencer
// Self-checking bench for alu_nibble_sequencer. A stub of the slice logic
// and the 13-way result mux answers the DUT combinationally. A word-level
// model of each op predicts the final result, the flags and the per-slice
// carries.
// ---------------------------------------------------------------------------
module tb_alu_nibble_sequencer;

  localparam int DATA_W = 32;
  localparam int NIB_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_cin;
  logic [NIB_W-1:0]  slice_a;
  logic [NIB_W-1:0]  slice_b;
  logic              slice_cin;
  logic [3:0]        mux_s;
  logic [NIB_W-1:0]  mux_y;
  logic              slice_cout;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_zero;
  logic              out_neg;
  logic              out_carry;
  logic              out_illegal;

  int checks   = 0;
  int failures = 0;

  // Phase the bench expects the DUT to be in: 0 idle, 1 run, 2 done.
  // The driver sets it just after the rising edge, and the checker reads
  // it on the falling edge.
  int phase = 0;

  logic [31:0] expResult;
  logic        expCarry;
  logic        expIllegal;

  logic [31:0] lastResult;
  logic        lastZero;
  logic        lastCarry;
  logic        lastIllegal;
  int          lastLatency;
  logic [7:0]  cinSeq;
  logic [31:0] sliceWord;
  logic [4:0]  stubSum;

  always #5 clk = ~clk;

  alu_nibble_sequencer #(.DATA_W(DATA_W), .NIB_W(NIB_W), .N_OPS(13)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_cin     (in_cin),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .mux_s      (mux_s),
    .mux_y      (mux_y),
    .slice_cout (slice_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_carry  (out_carry),
    .out_illegal(out_illegal)
  );

  // Stub of the per-op slice logic plus the result mux. Only ADD and SUB
  // produce a carry-out.
  always_comb begin
    stubSum    = '0;
    mux_y      = '0;
    slice_cout = 1'b0;
    case (mux_s)
      4'd0: begin
        stubSum = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};
        mux_y = stubSum[3:0]; slice_cout = stubSum[4];
      end
      4'd1: begin
        stubSum = {1'b0, slice_a} + {1'b0, ~slice_b} + {4'b0, slice_cin};
        mux_y = stubSum[3:0]; slice_cout = stubSum[4];
      end
      4'd2:  mux_y = slice_a & slice_b;
      4'd3:  mux_y = slice_a | slice_b;
      4'd4:  mux_y = slice_a ^ slice_b;
      4'd5:  mux_y = ~(slice_a | slice_b);
      4'd6:  mux_y = ~(slice_a & slice_b);
      4'd7:  mux_y = slice_a;
      4'd8:  mux_y = slice_b;
      4'd9:  mux_y = ~slice_a;
      4'd10: mux_y = ~(slice_a ^ slice_b);
      4'd11: mux_y = slice_a & ~slice_b;
      4'd12: mux_y = slice_a | ~slice_b;
      default: mux_y = '0;
    endcase
  end

  // Word-level model of a whole command
  function automatic void modelOp(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic cin,
                                  output logic [31:0] r, output logic c,
                                  output logic ill);
    logic [32:0] s;
    r = '0; c = 1'b0; ill = 1'b0; s = '0;
    case (op)
      4'd0: begin s = {1'b0, a} + {1'b0, b} + 33'(cin); r = s[31:0]; c = s[32]; end
      4'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'(cin); r = s[31:0]; c = s[32]; end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~(a | b);
      4'd6:  r = ~(a & b);
      4'd7:  r = a;
      4'd8:  r = b;
      4'd9:  r = ~a;
      4'd10: r = ~(a ^ b);
      4'd11: r = a & ~b;
      4'd12: r = a | ~b;
      default: ill = 1'b1;
    endcase
  endfunction

  // Carry into slice k: the carry out of the low 4k bits of the word sum
  function automatic logic carryInto(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic cin, input int k);
    logic [63:0] mask;
    logic [63:0] s;
    logic [31:0] bb;
    if (k == 0) return cin;
    if (op > 4'd1) return 1'b0;
    bb   = (op == 4'd1) ? ~b : b;
    mask = (64'd1 << (4 * k)) - 64'd1;
    s    = (64'(a) & mask) + (64'(bb) & mask) + 64'(cin);
    return s[4 * k];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the phase and the model expectations
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("out_valid", 32'(out_valid), 32'(phase == 2));
      checkOutput("in_ready", 32'(in_ready), 32'(phase == 0));
      if (phase != 1) begin
        checkOutput("mux_s_quiet", 32'(mux_s), 32'd0);
        checkOutput("slice_a_quiet", 32'(slice_a), 32'd0);
        checkOutput("slice_b_quiet", 32'(slice_b), 32'd0);
        checkOutput("slice_cin_quiet", 32'(slice_cin), 32'd0);
      end
      if (phase == 2) begin
        checkOutput("out_result", out_result, expResult);
        checkOutput("out_zero", 32'(out_zero), 32'(expResult == 32'd0));
        checkOutput("out_neg", 32'(out_neg), 32'(expResult[31]));
        checkOutput("out_carry", 32'(out_carry), 32'(expCarry));
        checkOutput("out_illegal", 32'(out_illegal), 32'(expIllegal));
      end
    end
  end

  // Issue one command and run it to completion. hold is the number of extra
  // cycles out_ready stays low after out_valid.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input int hold);
    int guard;
    int cyc;
    int expLat;
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    checkOutput("ready_before_cmd", 32'(in_ready), 32'd1);
    modelOp(op, a, b, cin, expResult, expCarry, expIllegal);
    expLat = expIllegal ? 1 : 9;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_cin = cin;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 4'($urandom); in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
    cyc = 1;
    phase = (cyc >= expLat) ? 2 : 1;
    cinSeq = '0; sliceWord = '0;
    while (!out_valid && cyc < 20) begin
      if (!expIllegal && cyc <= 8) begin
        cinSeq[cyc-1] = slice_cin;
        sliceWord[4*(cyc-1) +: 4] = slice_a;
        checkOutput("mux_s_run", 32'(mux_s), 32'(op));
        checkOutput("slice_a_run", 32'(slice_a), 32'(a[4*(cyc-1) +: 4]));
        checkOutput("slice_b_run", 32'(slice_b), 32'(b[4*(cyc-1) +: 4]));
        checkOutput("slice_cin_run", 32'(slice_cin), 32'(carryInto(op, a, b, cin, cyc-1)));
      end
      @(posedge clk); #1;
      cyc++;
      if (cyc >= expLat) phase = 2;
    end
    lastLatency = cyc;
    checkOutput("latency", 32'(cyc), 32'(expLat));
    lastResult = out_result; lastZero = out_zero; lastCarry = out_carry; lastIllegal = out_illegal;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    phase = 0;
    checkOutput("ready_after_handshake", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [3:0] rop;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_cin = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset values
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_result", out_result, 32'd0);
    checkOutput("rst_out_zero", 32'(out_zero), 32'd1);
    checkOutput("rst_out_carry", 32'(out_carry), 32'd0);
    checkOutput("rst_out_illegal", 32'(out_illegal), 32'd0);
    checkOutput("rst_mux_s", 32'(mux_s), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD with a carry that crosses a slice boundary
    applyStimulus(4'd0, 32'h0000000F, 32'h00000001, 1'b0, 0);
    checkOutput("add_lit_result", lastResult, 32'h00000010);
    checkOutput("add_lit_carry", 32'(lastCarry), 32'd0);
    checkOutput("add_lit_latency", 32'(lastLatency), 32'd9);

    // Full carry ripple
    applyStimulus(4'd0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
    checkOutput("ripple_lit_result", lastResult, 32'h0);
    checkOutput("ripple_lit_zero", 32'(lastZero), 32'd1);
    checkOutput("ripple_lit_carry", 32'(lastCarry), 32'd1);
    checkOutput("ripple_lit_cinseq", 32'(cinSeq), 32'h000000FE);

    // SUB with borrow-in convention: 5 - 3
    applyStimulus(4'd1, 32'd5, 32'd3, 1'b1, 1);
    checkOutput("sub_lit_result", lastResult, 32'd2);
    checkOutput("sub_lit_carry", 32'(lastCarry), 32'd1);

    // Illegal op
    applyStimulus(4'd13, 32'hDEADBEEF, 32'h12345678, 1'b1, 0);
    checkOutput("illegal_lit_flag", 32'(lastIllegal), 32'd1);
    checkOutput("illegal_lit_result", lastResult, 32'd0);
    checkOutput("illegal_lit_latency", 32'(lastLatency), 32'd1);

    // Output backpressure held for 5 cycles
    applyStimulus(4'd4, 32'h12345678, 32'hFFFF0000, 1'b0, 5);
    checkOutput("xor_lit_result", lastResult, 32'hEDCB5678);

    // Select and slice ordering
    applyStimulus(4'd7, 32'h76543210, 32'h0, 1'b0, 0);
    checkOutput("pass_lit_slices", sliceWord, 32'h76543210);
    checkOutput("pass_lit_result", lastResult, 32'h76543210);

    // Reset asserted mid-RUN at idx 3 (the fourth RUN cycle)
    expResult = 32'h0; expCarry = 1'b0; expIllegal = 1'b0;
    in_valid = 1'b1; in_op = 4'd0; in_a = 32'h11111111; in_b = 32'h22222222; in_cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    phase = 1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("midrun_mux_s", 32'(mux_s), 32'd0);
    checkOutput("midrun_slice_a", 32'(slice_a), 32'd1);
    rst_n = 1'b0;
    phase = 0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_result", out_result, 32'd0);
    checkOutput("midrst_zero", 32'(out_zero), 32'd1);
    checkOutput("midrst_mux_s", 32'(mux_s), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(4'd0, 32'h00001234, 32'h00004321, 1'b1, 0);
    checkOutput("post_rst_lit_result", lastResult, 32'h00005556);

    // Randomized commands, including occasional illegal op codes
    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      applyStimulus(rop, $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));
    end

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
